// File: rtl/c17_pattern_sequencer_pkg.sv
// Shared types and default sizes for the C17 pattern sequencer.
// Optional first-fail logging is enabled with C17SEQ_FAIL_LOG_EN.
package c17_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } seq_state_e;

    localparam int DEF_N_IN   = 5;
    localparam int DEF_N_OUT  = 2;
    localparam int DEF_SETTLE = 2;
    localparam int DEF_CNT_W  = 6;

    localparam logic [DEF_N_IN-1:0] PAT_LAST = {DEF_N_IN{1'b1}};

endpackage

// File: rtl/c17_pattern_sequencer_if.sv
// Campaign control/result bundle between the sequencer and its environment.
// First-fail log signals exist only when C17SEQ_FAIL_LOG_EN is defined.
interface c17_pattern_sequencer_if
    import c17_seq_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT,
    parameter int CNT_W = DEF_CNT_W
);
    logic             start_i;
    logic             abort_i;
    logic [N_IN-1:0]  pat_o;
    logic [N_OUT-1:0] gold_i;
    logic [N_OUT-1:0] dut_i;
    logic             busy_o;
    logic             done_o;
    logic             aborted_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic [N_OUT-1:0] err_bits_o;
    logic             pass_o;
`ifdef C17SEQ_FAIL_LOG_EN
    logic             first_fail_valid_o;
    logic [N_IN-1:0]  first_fail_pat_o;
    logic [N_OUT-1:0] first_fail_gold_o;
    logic [N_OUT-1:0] first_fail_dut_o;

    modport slave (
        input  start_i, abort_i, gold_i, dut_i,
        output pat_o, busy_o, done_o, aborted_o, err_cnt_o, err_bits_o, pass_o,
        output first_fail_valid_o, first_fail_pat_o, first_fail_gold_o, first_fail_dut_o
    );
    modport master (
        output start_i, abort_i, gold_i, dut_i,
        input  pat_o, busy_o, done_o, aborted_o, err_cnt_o, err_bits_o, pass_o,
        input  first_fail_valid_o, first_fail_pat_o, first_fail_gold_o, first_fail_dut_o
    );
`else
    modport slave (
        input  start_i, abort_i, gold_i, dut_i,
        output pat_o, busy_o, done_o, aborted_o, err_cnt_o, err_bits_o, pass_o
    );
    modport master (
        output start_i, abort_i, gold_i, dut_i,
        input  pat_o, busy_o, done_o, aborted_o, err_cnt_o, err_bits_o, pass_o
    );
`endif
endinterface

// File: rtl/c17_pattern_sequencer_scoreboard.sv
// Golden-vs-DUT compare: saturating mismatch count, sticky error bits and,
// with C17SEQ_FAIL_LOG_EN, a capture of the first failing pattern.
module c17_seq_scoreboard
    import c17_seq_pkg::*;
#(
    parameter int N_OUT = DEF_N_OUT,
    parameter int CNT_W = DEF_CNT_W
`ifdef C17SEQ_FAIL_LOG_EN
    ,
    parameter int N_IN  = DEF_N_IN
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             cmp_en_i,
`ifdef C17SEQ_FAIL_LOG_EN
    input  logic [N_IN-1:0]  pat_i,
    output logic             ff_valid_o,
    output logic [N_IN-1:0]  ff_pat_o,
    output logic [N_OUT-1:0] ff_gold_o,
    output logic [N_OUT-1:0] ff_dut_o,
`endif
    input  logic [N_OUT-1:0] gold_i,
    input  logic [N_OUT-1:0] dut_i,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [N_OUT-1:0] err_bits_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [N_OUT-1:0] diff_s;
    logic             mismatch_s;
    logic [CNT_W-1:0] err_cnt_q;
    logic [N_OUT-1:0] err_bits_q;

    assign diff_s     = gold_i ^ dut_i;
    assign mismatch_s = |diff_s;

    // Mismatch counter (holds at all-ones) and sticky per-output error bits
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            err_cnt_q  <= {CNT_W{1'b0}};
            err_bits_q <= {N_OUT{1'b0}};
        end else if (cmp_en_i && mismatch_s) begin
            if (err_cnt_q != CNT_MAX) begin
                err_cnt_q <= err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                err_cnt_q <= err_cnt_q;
            end
            err_bits_q <= err_bits_q | diff_s;
        end else begin
            err_cnt_q  <= err_cnt_q;
            err_bits_q <= err_bits_q;
        end
    end

    assign err_cnt_o  = err_cnt_q;
    assign err_bits_o = err_bits_q;

`ifdef C17SEQ_FAIL_LOG_EN
    logic             ff_valid_q;
    logic [N_IN-1:0]  ff_pat_q;
    logic [N_OUT-1:0] ff_gold_q;
    logic [N_OUT-1:0] ff_dut_q;

    // Capture only the first counted mismatch of a campaign
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            ff_valid_q <= 1'b0;
            ff_pat_q   <= {N_IN{1'b0}};
            ff_gold_q  <= {N_OUT{1'b0}};
            ff_dut_q   <= {N_OUT{1'b0}};
        end else if (cmp_en_i && mismatch_s && !ff_valid_q) begin
            ff_valid_q <= 1'b1;
            ff_pat_q   <= pat_i;
            ff_gold_q  <= gold_i;
            ff_dut_q   <= dut_i;
        end else begin
            ff_valid_q <= ff_valid_q;
            ff_pat_q   <= ff_pat_q;
            ff_gold_q  <= ff_gold_q;
            ff_dut_q   <= ff_dut_q;
        end
    end

    assign ff_valid_o = ff_valid_q;
    assign ff_pat_o   = ff_pat_q;
    assign ff_gold_o  = ff_gold_q;
    assign ff_dut_o   = ff_dut_q;
`endif

endmodule

// File: rtl/c17_pattern_sequencer.sv
// Exhaustive-pattern self-test controller for two C17 copies (golden, DUT).
// Define C17SEQ_FAIL_LOG_EN to add the first-fail capture outputs.
module c17_pattern_sequencer
    import c17_seq_pkg::*;
#(
    parameter int N_IN   = DEF_N_IN,
    parameter int N_OUT  = DEF_N_OUT,
    parameter int SETTLE = DEF_SETTLE,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    c17_pattern_sequencer_if.slave bus
);
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [N_IN-1:0] LAST_PAT    = {N_IN{1'b1}};

    seq_state_e       state_q;
    logic [N_IN-1:0]  pat_q;
    logic [3:0]       cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             aborted_q;
    logic             start_take_s;
    logic             abort_take_s;
    logic             cmp_en_s;
    logic [CNT_W-1:0] err_cnt_s;
    logic [N_OUT-1:0] err_bits_s;

    assign start_take_s = (state_q == ST_IDLE) && bus.start_i;
    assign abort_take_s = ((state_q == ST_SETTLE) || (state_q == ST_COMPARE)) && bus.abort_i;
    // An abort in the compare cycle throws that comparison away
    assign cmp_en_s     = (state_q == ST_COMPARE) && !bus.abort_i;

    // Campaign FSM, pattern register and settle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            pat_q     <= {N_IN{1'b0}};
            cnt_q     <= 4'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else if (abort_take_s) begin
            state_q   <= ST_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            aborted_q <= 1'b1;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start_i) begin
                        state_q   <= ST_SETTLE;
                        pat_q     <= {N_IN{1'b0}};
                        cnt_q     <= 4'd0;
                        busy_q    <= 1'b1;
                        aborted_q <= 1'b0;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SETTLE: begin
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == SETTLE_LAST) begin
                        state_q <= ST_COMPARE;
                    end else begin
                        state_q <= ST_SETTLE;
                    end
                end
                ST_COMPARE: begin
                    if (pat_q == LAST_PAT) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_SETTLE;
                        pat_q   <= pat_q + {{(N_IN-1){1'b0}}, 1'b1};
                        cnt_q   <= 4'd0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    c17_seq_scoreboard #(
        .N_OUT (N_OUT),
        .CNT_W (CNT_W)
`ifdef C17SEQ_FAIL_LOG_EN
        ,
        .N_IN  (N_IN)
`endif
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (start_take_s),
        .cmp_en_i   (cmp_en_s),
`ifdef C17SEQ_FAIL_LOG_EN
        .pat_i      (pat_q),
        .ff_valid_o (bus.first_fail_valid_o),
        .ff_pat_o   (bus.first_fail_pat_o),
        .ff_gold_o  (bus.first_fail_gold_o),
        .ff_dut_o   (bus.first_fail_dut_o),
`endif
        .gold_i     (bus.gold_i),
        .dut_i      (bus.dut_i),
        .err_cnt_o  (err_cnt_s),
        .err_bits_o (err_bits_s)
    );

    assign bus.pat_o      = pat_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.aborted_o  = aborted_q;
    assign bus.err_cnt_o  = err_cnt_s;
    assign bus.err_bits_o = err_bits_s;
    assign bus.pass_o     = (err_cnt_s == {CNT_W{1'b0}}) && !aborted_q;

endmodule
